ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register of the RV32I core; sits directly upstream of the ALU.
- Captures decoded instruction fields from decode under a valid/ready handshake and holds them.
- Resolves EX/MEM and MEM/WB operand forwarding.
- Drives the ALU's 4-bit operation code and its two 32-bit operands, plus destination info for later stages.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1_data, in_rs2_data  in  XLEN  register file read data
- in_imm  in  XLEN  sign-extended immediate
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  REG_ADDR_W  register indices
- in_opcode  in  7  instruction opcode
- in_funct3  in  3  funct3
- in_funct7_b5  in  1  instruction bit 30
- flush  in  1  squash held and incoming instruction
- fwd_exmem_we, fwd_memwb_we  in  1  later-stage write enables
- fwd_exmem_rd, fwd_memwb_rd  in  REG_ADDR_W  later-stage destinations
- fwd_exmem_data, fwd_memwb_data  in  XLEN  later-stage results
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream consumes this cycle
- alu_operation  out  4  to ALU operation
- alu_in_x, alu_in_y  out  XLEN  to ALU operands
- out_rd_addr  out  REG_ADDR_W  destination
- out_rd_we  out  1  writeback enable
- out_illegal  out  1  unsupported opcode/funct
- out_pc  out  XLEN  held PC

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all held fields 0. Resulting outputs: alu_operation=4'b1111, alu_in_x=0, alu_in_y=0, out_rd_we=0, out_illegal=0, out_rd_addr=0, out_pc=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in when in_valid && in_ready: fields registered, out_valid=1 next cycle, latency 1.
  - Transfer out when out_valid && out_ready; if there is no simultaneous transfer in, out_valid clears next cycle.
  - Simultaneous in/out transfers give back-to-back throughput of 1 per cycle.
- Holding: while out_valid && !out_ready, held fields are stable except for the forwarding refresh below.
- Flush (synchronous): out_valid=0 next cycle and overrides any capture that cycle. in_ready still follows its formula; a transfer accepted during flush is discarded.
- ALU op codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, PASS_X=1111.
- Decode of alu_operation, X/Y sources and rd_we (combinational from held fields):
  - R-type 0110011, X=rs1, Y=rs2: funct3 000 gives ADD (b5=0) or SUB (b5=1); 111 AND; 110 OR; 010 SLT.
  - I-type 0010011, X=rs1, Y=imm: 000 ADD, 111 AND, 110 OR, 010 SLT.
  - Load 0000011 / store 0100011: ADD, X=rs1, Y=imm.
  - Branch 1100011, X=rs1, Y=rs2: funct3 000/001 SUB; 100 SLT.
  - LUI 0110111: ADD, X=0, Y=imm. AUIPC 0010111: ADD, X=pc, Y=imm.
  - Any other opcode/funct3 combination: PASS_X, out_illegal=1 (gated by out_valid), rd_we=0.
  - out_rd_we=1 only when out_valid, rd!=0, not illegal, and opcode is R, I, load, LUI or AUIPC.
- Forwarding (register-sourced operands only):
  - Match when we=1, rd!=0, rd==rs.
  - EX/MEM has priority over MEM/WB; with no match the held data is used.
  - Operand path is combinational, forwarded value to ALU in the same cycle.
- Forwarding refresh: each cycle while out_valid && !out_ready, a matching forwarded value is written into held rs data. This keeps the value after the producer retires.
- Capture cycle: registers in_rs*_data as given. Decode forwards same-cycle writes through the register file.
- Reset mid-stall drops the held instruction.

Decomposition:
- Shared package holds:
  - ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_PASS_X), also used by the ALU.
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC).
- One combinational sub-module alu_op_decode: opcode/funct3/funct7_b5 in, alu_operation, operand selects, rd_we class and illegal out.
- Handshake and forwarding stay in ex_operand_stage.

Test Plan:
- Reset, then release with out_ready=1. Present R-type funct3=000, b5=1, rs1=5, rs2=3 → next cycle out_valid=1, alu_operation=0110, x=5, y=3, out_rd_we=1.
- I-type ADDI with imm=-4 (0xFFFFFFFC), rs1=10 → alu_operation=0010, y=0xFFFFFFFC. Same instruction with rd=0 → out_rd_we=0.
- Hold with out_ready=0 for 3 cycles while fwd_memwb_we=1, rd=rs1, data=0x77 for 1 cycle. After release alu_in_x=0x77; in_ready=0 throughout the stall.
- Drive EX/MEM and MEM/WB matching rs2 with 0x11 and 0x22 → alu_in_y=0x11. Drive a match with rd=0 → held data used.
- Flush asserted together with in_valid=1 → out_valid=0 next cycle, no output transfer.
- Opcode 1110011 → alu_operation=1111, out_illegal=1, out_rd_we=0. Assert rst_n=0 mid-stall → out_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared constants and the ID/EX bundle for the RV32I execute front end.
// ALU op codes here are also consumed by the ALU itself.
package ex_operand_stage_pkg;

  localparam int PKG_XLEN  = 32;
  localparam int PKG_REG_W = 5;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_PASS_X = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    X_RS1,
    X_PC,
    X_ZERO
  } x_sel_e;

  typedef enum logic {
    Y_RS2,
    Y_IMM
  } y_sel_e;

  typedef struct packed {
    logic [PKG_XLEN-1:0]  pc;
    logic [PKG_XLEN-1:0]  rs1_data;
    logic [PKG_XLEN-1:0]  rs2_data;
    logic [PKG_XLEN-1:0]  imm;
    logic [PKG_REG_W-1:0] rs1_addr;
    logic [PKG_REG_W-1:0] rs2_addr;
    logic [PKG_REG_W-1:0] rd_addr;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_b5;
  } id_ex_t;

endpackage

// File: rtl/ex_operand_stage_alu_op_decode.sv
// Combinational decode of ALU operation, operand sources and writeback class.
// Unsupported encodings fall back to PASS_X with writeback suppressed.
module alu_op_decode
  import ex_operand_stage_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_operation,
  output x_sel_e     x_sel,
  output y_sel_e     y_sel,
  output logic       rd_we,
  output logic       illegal
);

  logic [3:0] arith;
  logic       arith_ok;

  always_comb begin
    arith    = ALU_PASS_X;
    arith_ok = 1'b1;
    unique case (funct3)
      3'b000:  arith = ALU_ADD;
      3'b111:  arith = ALU_AND;
      3'b110:  arith = ALU_OR;
      3'b010:  arith = ALU_SLT;
      default: arith_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_operation = ALU_PASS_X;
    x_sel         = X_RS1;
    y_sel         = Y_RS2;
    rd_we         = 1'b0;
    illegal       = 1'b0;
    unique case (1'b1)
      opcode == OP_R: begin
        alu_operation = (funct3 == 3'b000 && funct7_b5) ? ALU_SUB : arith;
        rd_we         = 1'b1;
        illegal       = !arith_ok;
      end
      opcode == OP_I: begin
        alu_operation = arith;
        y_sel         = Y_IMM;
        rd_we         = 1'b1;
        illegal       = !arith_ok;
      end
      opcode == OP_LOAD, opcode == OP_STORE: begin
        alu_operation = ALU_ADD;
        y_sel         = Y_IMM;
        rd_we         = (opcode == OP_LOAD);
      end
      opcode == OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001)
          alu_operation = ALU_SUB;
        else if (funct3 == 3'b100)
          alu_operation = ALU_SLT;
        else
          illegal = 1'b1;
      end
      opcode == OP_LUI: begin
        alu_operation = ALU_ADD;
        x_sel         = X_ZERO;
        y_sel         = Y_IMM;
        rd_we         = 1'b1;
      end
      opcode == OP_AUIPC: begin
        alu_operation = ALU_ADD;
        x_sel         = X_PC;
        y_sel         = Y_IMM;
        rd_we         = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_operation = ALU_PASS_X;
      rd_we         = 1'b0;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU: valid/ready capture, operand forwarding,
// and refresh of held operands while stalled so retired producers are kept.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN       = PKG_XLEN,
  parameter int REG_ADDR_W = PKG_REG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7_b5,
  input  logic                  flush,
  input  logic                  fwd_exmem_we,
  input  logic                  fwd_memwb_we,
  input  logic [REG_ADDR_W-1:0] fwd_exmem_rd,
  input  logic [REG_ADDR_W-1:0] fwd_memwb_rd,
  input  logic [XLEN-1:0]       fwd_exmem_data,
  input  logic [XLEN-1:0]       fwd_memwb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            alu_operation,
  output logic [XLEN-1:0]       alu_in_x,
  output logic [XLEN-1:0]       alu_in_y,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_rd_we,
  output logic                  out_illegal,
  output logic [XLEN-1:0]       out_pc
);

  id_ex_t held;
  logic   valid;
  logic   take;
  logic   stall;

  logic ex_rs1, ex_rs2, wb_rs1, wb_rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;

  x_sel_e x_sel;
  y_sel_e y_sel;
  logic   dec_rd_we;
  logic   dec_illegal;

  assign in_ready = !valid || out_ready;
  assign take     = in_valid && in_ready;
  assign stall    = valid && !out_ready;

  assign ex_rs1 = fwd_exmem_we && |fwd_exmem_rd
                  && fwd_exmem_rd == held.rs1_addr;
  assign ex_rs2 = fwd_exmem_we && |fwd_exmem_rd
                  && fwd_exmem_rd == held.rs2_addr;
  assign wb_rs1 = fwd_memwb_we && |fwd_memwb_rd
                  && fwd_memwb_rd == held.rs1_addr;
  assign wb_rs2 = fwd_memwb_we && |fwd_memwb_rd
                  && fwd_memwb_rd == held.rs2_addr;

  assign rs1_val = ex_rs1 ? fwd_exmem_data
                 : wb_rs1 ? fwd_memwb_data
                 : held.rs1_data;
  assign rs2_val = ex_rs2 ? fwd_exmem_data
                 : wb_rs2 ? fwd_memwb_data
                 : held.rs2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      held  <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (take)
        valid <= 1'b1;
      else if (out_ready)
        valid <= 1'b0;
      if (take && !flush) begin
        held <= '{
          pc:        in_pc,
          rs1_data:  in_rs1_data,
          rs2_data:  in_rs2_data,
          imm:       in_imm,
          rs1_addr:  in_rs1_addr,
          rs2_addr:  in_rs2_addr,
          rd_addr:   in_rd_addr,
          opcode:    in_opcode,
          funct3:    in_funct3,
          funct7_b5: in_funct7_b5
        };
      end else if (stall) begin
        held.rs1_data <= rs1_val;
        held.rs2_data <= rs2_val;
      end
    end
  end

  alu_op_decode u_dec (
    .opcode        (held.opcode),
    .funct3        (held.funct3),
    .funct7_b5     (held.funct7_b5),
    .alu_operation (alu_operation),
    .x_sel         (x_sel),
    .y_sel         (y_sel),
    .rd_we         (dec_rd_we),
    .illegal       (dec_illegal)
  );

  always_comb begin
    alu_in_x = rs1_val;
    unique case (x_sel)
      X_PC:    alu_in_x = held.pc;
      X_ZERO:  alu_in_x = '0;
      default: alu_in_x = rs1_val;
    endcase
  end

  assign alu_in_y    = (y_sel == Y_IMM) ? held.imm : rs2_val;
  assign out_valid   = valid;
  assign out_rd_addr = held.rd_addr;
  assign out_pc      = held.pc;
  assign out_rd_we   = valid && |held.rd_addr && dec_rd_we;
  assign out_illegal = valid && dec_illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vectors, a slot-level reference
// model checked every falling edge, and literal spot checks.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_b5;
  logic        flush;
  logic        fwd_exmem_we, fwd_memwb_we;
  logic [4:0]  fwd_exmem_rd, fwd_memwb_rd;
  logic [31:0] fwd_exmem_data, fwd_memwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_operation;
  logic [31:0] alu_in_x, alu_in_y;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;
  logic        out_illegal;
  logic [31:0] out_pc;

  int total = 0;
  int bad   = 0;

  ex_operand_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rd_addr     (in_rd_addr),
    .in_opcode      (in_opcode),
    .in_funct3      (in_funct3),
    .in_funct7_b5   (in_funct7_b5),
    .flush          (flush),
    .fwd_exmem_we   (fwd_exmem_we),
    .fwd_memwb_we   (fwd_memwb_we),
    .fwd_exmem_rd   (fwd_exmem_rd),
    .fwd_memwb_rd   (fwd_memwb_rd),
    .fwd_exmem_data (fwd_exmem_data),
    .fwd_memwb_data (fwd_memwb_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_operation  (alu_operation),
    .alu_in_x       (alu_in_x),
    .alu_in_y       (alu_in_y),
    .out_rd_addr    (out_rd_addr),
    .out_rd_we      (out_rd_we),
    .out_illegal    (out_illegal),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one instruction slot
  bit          m_valid;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [6:0]  m_opc;
  logic [2:0]  m_f3;
  logic        m_b5;

  function automatic logic [31:0] mfwd(input logic [4:0] a,
                                       input logic [31:0] d);
    if (a != 0 && fwd_exmem_we && fwd_exmem_rd == a) return fwd_exmem_data;
    if (a != 0 && fwd_memwb_we && fwd_memwb_rd == a) return fwd_memwb_data;
    return d;
  endfunction

  // xs: 0 rs1, 1 pc, 2 zero; ys: 0 rs2, 1 imm
  function automatic void spec_decode(
    input logic [6:0] opc, input logic [2:0] f3, input logic b5,
    output logic [3:0] op, output int xs, output int ys,
    output bit wb, output bit ill);
    op = 4'hF; xs = 0; ys = 0; wb = 0; ill = 0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      ys = (opc == 7'b0010011) ? 1 : 0;
      wb = 1;
      if (f3 == 3'd0) op = (opc == 7'b0110011 && b5) ? 4'd6 : 4'd2;
      else if (f3 == 3'd7) op = 4'd0;
      else if (f3 == 3'd6) op = 4'd1;
      else if (f3 == 3'd2) op = 4'd7;
      else ill = 1;
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      op = 4'd2; ys = 1; wb = (opc == 7'b0000011);
    end else if (opc == 7'b1100011) begin
      if (f3 <= 3'd1) op = 4'd6;
      else if (f3 == 3'd4) op = 4'd7;
      else ill = 1;
    end else if (opc == 7'b0110111) begin
      op = 4'd2; xs = 2; ys = 1; wb = 1;
    end else if (opc == 7'b0010111) begin
      op = 4'd2; xs = 1; ys = 1; wb = 1;
    end else begin
      ill = 1;
    end
    if (ill) begin
      op = 4'hF; wb = 0;
    end
  endfunction

  bit enters, leaves;
  always_comb begin
    leaves = m_valid && out_ready;
    enters = in_valid && (!m_valid || leaves);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= !flush && (enters || (m_valid && !leaves));
      if (enters && !flush) begin
        m_pc <= in_pc; m_rs1 <= in_rs1_data; m_rs2 <= in_rs2_data;
        m_imm <= in_imm; m_rs1a <= in_rs1_addr; m_rs2a <= in_rs2_addr;
        m_rd <= in_rd_addr; m_opc <= in_opcode; m_f3 <= in_funct3;
        m_b5 <= in_funct7_b5;
      end else if (m_valid && !out_ready) begin
        m_rs1 <= mfwd(m_rs1a, m_rs1);
        m_rs2 <= mfwd(m_rs2a, m_rs2);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] op;
    int xs, ys;
    bit wb, ill;
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
    if (m_valid) begin
      spec_decode(m_opc, m_f3, m_b5, op, xs, ys, wb, ill);
      chk("m_alu_op", {28'd0, alu_operation}, {28'd0, op});
      chk("m_illegal", {31'd0, out_illegal}, {31'd0, ill});
      chk("m_rd_we", {31'd0, out_rd_we}, {31'd0, wb && m_rd != 0});
      chk("m_rd_addr", {27'd0, out_rd_addr}, {27'd0, m_rd});
      chk("m_pc", out_pc, m_pc);
      if (!ill) begin
        chk("m_x", alu_in_x,
            xs == 1 ? m_pc : xs == 2 ? 32'd0 : mfwd(m_rs1a, m_rs1));
        chk("m_y", alu_in_y, ys == 1 ? m_imm : mfwd(m_rs2a, m_rs2));
      end
    end else begin
      chk("m_idle_rd_we", {31'd0, out_rd_we}, 32'd0);
      chk("m_idle_illegal", {31'd0, out_illegal}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(
    input logic [6:0] opc, input logic [2:0] f3, input logic b5,
    input logic [4:0] rs1a, input logic [31:0] rs1d,
    input logic [4:0] rs2a, input logic [31:0] rs2d,
    input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
    in_opcode = opc; in_funct3 = f3; in_funct7_b5 = b5;
    in_rs1_addr = rs1a; in_rs1_data = rs1d;
    in_rs2_addr = rs2a; in_rs2_data = rs2d;
    in_rd_addr = rd; in_imm = imm; in_pc = pc;
    in_valid = 1'b1;
  endtask

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        b5;
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{7'b0100011, 3'd2, 1'b0, 5'd2, 32'h1000, 5'd3, 32'h55, 5'd0, 32'd8};
    vecs[1]  = '{7'b0000011, 3'd2, 1'b0, 5'd2, 32'h2000, 5'd0, 32'h0, 5'd4, 32'hFFFFFFF8};
    vecs[2]  = '{7'b1100011, 3'd0, 1'b0, 5'd4, 32'h7, 5'd3, 32'h9, 5'd0, 32'h10};
    vecs[3]  = '{7'b1100011, 3'd1, 1'b0, 5'd2, 32'h7, 5'd5, 32'h9, 5'd0, 32'h10};
    vecs[4]  = '{7'b1100011, 3'd4, 1'b0, 5'd6, 32'h7, 5'd2, 32'h9, 5'd0, 32'h10};
    vecs[5]  = '{7'b1100011, 3'd5, 1'b0, 5'd6, 32'h7, 5'd2, 32'h9, 5'd0, 32'h10};
    vecs[6]  = '{7'b0110011, 3'd7, 1'b0, 5'd1, 32'hF0F0, 5'd3, 32'hFF, 5'd9, 32'h0};
    vecs[7]  = '{7'b0110011, 3'd6, 1'b0, 5'd2, 32'hF0F0, 5'd8, 32'hFF, 5'd9, 32'h0};
    vecs[8]  = '{7'b0110011, 3'd2, 1'b0, 5'd8, 32'h1, 5'd9, 32'h2, 5'd10, 32'h0};
    vecs[9]  = '{7'b0110011, 3'd1, 1'b0, 5'd8, 32'h1, 5'd9, 32'h2, 5'd10, 32'h0};
    vecs[10] = '{7'b0010011, 3'd7, 1'b0, 5'd2, 32'hAA, 5'd0, 32'h0, 5'd11, 32'h0F};
    vecs[11] = '{7'b0010011, 3'd6, 1'b0, 5'd3, 32'hAA, 5'd0, 32'h0, 5'd12, 32'h0F};
    vecs[12] = '{7'b0010011, 3'd2, 1'b0, 5'd1, 32'hAA, 5'd0, 32'h0, 5'd13, 32'h0F};
    vecs[13] = '{7'b0110011, 3'd0, 1'b1, 5'd1, 32'h0, 5'd0, 32'h0, 5'd14, 32'h0};
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_opcode = '0; in_funct3 = '0; in_funct7_b5 = 1'b0;
    fwd_exmem_we = 1'b0; fwd_memwb_we = 1'b0;
    fwd_exmem_rd = '0; fwd_memwb_rd = '0;
    fwd_exmem_data = '0; fwd_memwb_data = '0;

    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op", {28'd0, alu_operation}, 32'hF);
    chk("rst_x", alu_in_x, 32'd0);
    chk("rst_y", alu_in_y, 32'd0);
    chk("rst_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_rd_addr", {27'd0, out_rd_addr}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    rst_n = 1'b1;

    // R-type SUB
    set_instr(7'b0110011, 3'd0, 1'b1, 5'd1, 32'd5, 5'd2, 32'd3,
              5'd3, 32'd0, 32'h100);
    tick(); in_valid = 1'b0; #1;
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_op", {28'd0, alu_operation}, 32'h6);
    chk("sub_x", alu_in_x, 32'd5);
    chk("sub_y", alu_in_y, 32'd3);
    chk("sub_rd_we", {31'd0, out_rd_we}, 32'd1);

    // ADDI with negative immediate, then rd=0
    set_instr(7'b0010011, 3'd0, 1'b0, 5'd1, 32'd10, 5'd0, 32'd0,
              5'd4, 32'hFFFFFFFC, 32'h104);
    tick(); in_valid = 1'b0; #1;
    chk("addi_op", {28'd0, alu_operation}, 32'h2);
    chk("addi_x", alu_in_x, 32'd10);
    chk("addi_y", alu_in_y, 32'hFFFFFFFC);
    chk("addi_rd_we", {31'd0, out_rd_we}, 32'd1);
    in_rd_addr = 5'd0; in_valid = 1'b1;
    tick(); in_valid = 1'b0; #1;
    chk("addi_rd0_we", {31'd0, out_rd_we}, 32'd0);

    // stall with a one-cycle MEM/WB producer on rs1
    set_instr(7'b0010011, 3'd0, 1'b0, 5'd7, 32'd1, 5'd0, 32'd0,
              5'd5, 32'h10, 32'h108);
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    fwd_memwb_we = 1'b1; fwd_memwb_rd = 5'd7; fwd_memwb_data = 32'h77;
    #1;
    chk("stall_x0", alu_in_x, 32'h77);
    chk("stall_rdy0", {31'd0, in_ready}, 32'd0);
    tick(); fwd_memwb_we = 1'b0; #1;
    chk("stall_x1", alu_in_x, 32'h77);
    chk("stall_rdy1", {31'd0, in_ready}, 32'd0);
    tick(); #1;
    chk("stall_x2", alu_in_x, 32'h77);
    chk("stall_rdy2", {31'd0, in_ready}, 32'd0);
    tick(); out_ready = 1'b1; #1;
    chk("release_x", alu_in_x, 32'h77);
    tick();

    // EX/MEM beats MEM/WB on rs2, value kept after both retire
    set_instr(7'b0110011, 3'd0, 1'b0, 5'd1, 32'd2, 5'd9, 32'h99,
              5'd6, 32'd0, 32'h10C);
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd9; fwd_exmem_data = 32'h11;
    fwd_memwb_we = 1'b1; fwd_memwb_rd = 5'd9; fwd_memwb_data = 32'h22;
    #1;
    chk("prio_y", alu_in_y, 32'h11);
    tick(); fwd_exmem_we = 1'b0; fwd_memwb_we = 1'b0; #1;
    chk("prio_kept_y", alu_in_y, 32'h11);
    out_ready = 1'b1;
    tick();

    // match on x0 never forwards
    set_instr(7'b0110011, 3'd0, 1'b0, 5'd1, 32'd2, 5'd0, 32'h5A,
              5'd6, 32'd0, 32'h110);
    fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd0; fwd_exmem_data = 32'hDEAD;
    fwd_memwb_we = 1'b1; fwd_memwb_rd = 5'd0; fwd_memwb_data = 32'hBEEF;
    tick(); in_valid = 1'b0; #1;
    chk("x0_y", alu_in_y, 32'h5A);
    fwd_exmem_we = 1'b0; fwd_memwb_we = 1'b0;

    // back-to-back LUI then AUIPC
    set_instr(7'b0110111, 3'd0, 1'b0, 5'd3, 32'h3, 5'd0, 32'd0,
              5'd8, 32'h12345000, 32'h114);
    tick();
    set_instr(7'b0010111, 3'd0, 1'b0, 5'd3, 32'h3, 5'd0, 32'd0,
              5'd9, 32'h1000, 32'h118);
    #1;
    chk("lui_x", alu_in_x, 32'd0);
    chk("lui_y", alu_in_y, 32'h12345000);
    tick(); in_valid = 1'b0; #1;
    chk("auipc_x", alu_in_x, 32'h118);
    chk("auipc_y", alu_in_y, 32'h1000);
    chk("auipc_b2b", {31'd0, out_valid}, 32'd1);

    // table sweep under live forwarding, checked by the model
    fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd2; fwd_exmem_data = 32'hABC;
    fwd_memwb_we = 1'b1; fwd_memwb_rd = 5'd3; fwd_memwb_data = 32'h333;
    for (int i = 0; i < 14; i++) begin
      set_instr(vecs[i].opc, vecs[i].f3, vecs[i].b5,
                vecs[i].rs1a, vecs[i].rs1d, vecs[i].rs2a, vecs[i].rs2d,
                vecs[i].rd, vecs[i].imm, 32'h300 + 32'(4 * i));
      out_ready = (i % 4 != 3);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    fwd_exmem_we = 1'b0; fwd_memwb_we = 1'b0;

    // flush squashes the incoming instruction
    set_instr(7'b0110011, 3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2,
              5'd3, 32'd0, 32'h120);
    flush = 1'b1;
    tick(); in_valid = 1'b0; flush = 1'b0; #1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);

    // illegal opcode, then async reset mid-stall
    set_instr(7'b1110011, 3'd0, 1'b0, 5'd1, 32'd3, 5'd2, 32'd4,
              5'd7, 32'd0, 32'h200);
    tick(); in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("ill_op", {28'd0, alu_operation}, 32'hF);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_rd_we", {31'd0, out_rd_we}, 32'd0);
    tick(); #1;
    chk("ill_held", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0; #1;
    chk("async_rst", {31'd0, out_valid}, 32'd0);
    tick(); rst_n = 1'b1; out_ready = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
